// File: rtl/data_mem_port.sv
// RV32I memory-access stage: decodes execute's load/store request into a single-outstanding
// bus transaction with timeout, and returns extended load data or an error to writeback.
module data_mem_port #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mem_enablen,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_q, load_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lane_q, lane_d;
  logic            bus_cs_q, bus_cs_d;
  logic            bus_we_q, bus_we_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic [3:0]      dec_mask;
  logic            dec_bad;
  logic            dec_noop;
  logic            dec_misal;
  logic            dec_err;

  // Pick the addressed lane out of the read word, then sign- or zero-extend it.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  extend_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend_load = {{16{sh[15]}}, sh[15:0]};
      3'b010:  extend_load = sh;
      3'b100:  extend_load = {24'd0, sh[7:0]};
      3'b101:  extend_load = {16'd0, sh[15:0]};
      default: extend_load = 32'd0;
    endcase
  endfunction

  // Size mask and legality of the incoming op; stores take their size from the strobes.
  always_comb begin
    dec_mask = 4'b0000;
    dec_bad  = 1'b0;
    dec_noop = 1'b0;
    if (req_load) begin
      case (req_funct3)
        3'b000, 3'b100: dec_mask = 4'b0001;
        3'b001, 3'b101: dec_mask = 4'b0011;
        3'b010:         dec_mask = 4'b1111;
        default:        dec_bad  = 1'b1;
      endcase
      if (req_mem_enablen != 4'b1111) begin
        dec_bad = 1'b1;
      end else begin
        dec_bad = dec_bad;
      end
    end else begin
      case (req_mem_enablen)
        4'b1111: dec_noop = 1'b1;
        4'b1110: dec_mask = 4'b0001;
        4'b1100: dec_mask = 4'b0011;
        4'b0000: dec_mask = 4'b1111;
        default: dec_bad  = 1'b1;
      endcase
    end
  end

  assign dec_misal = ((dec_mask == 4'b0011) && req_addr[0]) ||
                     ((dec_mask == 4'b1111) && (req_addr[1:0] != 2'b00));
  assign dec_err   = dec_bad | dec_misal;

  // Next-state and registered-output logic for the IDLE/BUS/RESP sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_d       = load_q;
    f3_d         = f3_q;
    lane_d       = lane_q;
    bus_cs_d     = bus_cs_q;
    bus_we_d     = bus_we_q;
    bus_be_d     = bus_be_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          load_d = req_load;
          f3_d   = req_funct3;
          lane_d = req_addr[1:0];
          cnt_d  = '0;
          if (dec_err || dec_noop) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = dec_err;
          end else begin
            state_d     = BUS;
            bus_cs_d    = 1'b1;
            bus_we_d    = ~req_load;
            bus_be_d    = dec_mask << req_addr[1:0];
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_wdata_d = req_load ? 32'd0 : (req_wdata << {req_addr[1:0], 3'b000});
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        // An ack in the expiry cycle still completes the access normally.
        if (bus_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = ~bus_ack;
          resp_rdata_d = (bus_ack && load_q) ? extend_load(f3_q, bus_rdata, lane_q) : 32'd0;
          cnt_d        = '0;
          bus_cs_d     = 1'b0;
          bus_we_d     = 1'b0;
          bus_be_d     = 4'b0000;
          bus_addr_d   = 32'd0;
          bus_wdata_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        bus_cs_d    = 1'b0;
        bus_we_d    = 1'b0;
        bus_be_d    = 4'b0000;
        bus_addr_d  = 32'd0;
        bus_wdata_d = 32'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      load_q       <= 1'b0;
      f3_q         <= 3'd0;
      lane_q       <= 2'd0;
      bus_cs_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_be_q     <= 4'd0;
      bus_addr_q   <= 32'd0;
      bus_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      load_q       <= load_d;
      f3_q         <= f3_d;
      lane_q       <= lane_d;
      bus_cs_q     <= bus_cs_d;
      bus_we_q     <= bus_we_d;
      bus_be_q     <= bus_be_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign bus_cs     = bus_cs_q;
  assign bus_we     = bus_we_q;
  assign bus_be     = bus_be_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Scoreboard bench for data_mem_port: directed ops push expected bus accesses and responses;
// independent bus-side and response-side monitors pop and compare.
module tb_data_mem_port;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_mem_enablen = 4'b1111;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_cs;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  data_mem_port #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_mem_enablen(req_mem_enablen),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [68:0] fields;   // {we, be, addr, wdata}
    int          len;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int ack_after = 0;
  logic [31:0] rd_word = 32'd0;
  logic stray_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bus slave model plus bus-side scoreboard
  int       cs_cnt = 0;
  bus_exp_t cur;
  bit       have_cur = 1'b0;
  bit       stable = 1'b1;
  always @(negedge clk) begin
    if (bus_cs) begin
      cs_cnt++;
      if (cs_cnt == 1) begin
        if (bus_q.size() == 0) begin
          chk(1'b0, "unexpected_bus", {3'd0, bus_we, bus_be, bus_addr, bus_wdata}, 72'd0);
          have_cur = 1'b0;
        end else begin
          cur = bus_q.pop_front();
          have_cur = 1'b1;
          stable = 1'b1;
          chk({bus_we, bus_be, bus_addr, bus_wdata} == cur.fields, "bus_fields",
              {3'd0, bus_we, bus_be, bus_addr, bus_wdata}, {3'd0, cur.fields});
        end
      end else if (have_cur && ({bus_we, bus_be, bus_addr, bus_wdata} != cur.fields)) begin
        stable = 1'b0;
      end
    end else if (cs_cnt > 0) begin
      if (have_cur)
        chk(stable && (cs_cnt == cur.len), "bus_cs_len", {stable, 71'(cs_cnt)}, {1'b1, 71'(cur.len)});
      have_cur = 1'b0;
      cs_cnt = 0;
    end
    bus_ack   = stray_ack | (bus_cs && (ack_after != 0) && (cs_cnt == ack_after));
    bus_rdata = rd_word;
  end

  // Response-side scoreboard
  always @(negedge clk) begin
    if (resp_valid) begin
      if (resp_q.size() == 0) begin
        chk(1'b0, "unexpected_resp", {39'd0, resp_err, resp_rdata}, 72'd0);
      end else begin
        resp_exp_t e;
        e = resp_q.pop_front();
        chk({resp_rdata, resp_err, cyc} == {e.rdata, e.err, e.cyc}, "resp",
            {7'd0, resp_rdata, resp_err, 32'(cyc)}, {7'd0, e.rdata, e.err, 32'(e.cyc)});
      end
    end
  end

  task automatic issue(input logic load, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] en, input int ack_n,
                       input logic [31:0] rword, input int bus_len, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input bit want_resp);
    int w;
    int k;
    bus_exp_t b;
    resp_exp_t r;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 600) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk(1'b0, "ready_timeout", 72'd0, 72'd1);
    end else begin
      ack_after = ack_n;
      rd_word = rword;
      req_valid = 1'b1;
      req_load = load;
      req_funct3 = f3;
      req_addr = addr;
      req_wdata = wdata;
      req_mem_enablen = en;
      k = cyc;
      if (bus_len > 0) begin
        b.fields = {~load, exp_be, addr[31:2], 2'b00, exp_wdata};
        b.len = bus_len;
        bus_q.push_back(b);
      end
      if (want_resp) begin
        r.rdata = exp_rdata;
        r.err = exp_err;
        r.cyc = k + 1 + bus_len;
        resp_q.push_back(r);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk({req_ready, bus_cs, resp_valid, resp_err, bus_we, bus_be, bus_addr, bus_wdata, resp_rdata} == 104'd0,
        "reset_state", {req_ready, bus_cs, resp_valid, resp_err, bus_we, bus_be, bus_addr[31:0], bus_wdata[31:0]},
        72'd0);
    rst = 1'b0;

    // SW aligned, ack in second cs cycle
    issue(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0000, 2, 32'd0, 2, 4'b1111, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
    // SB into top lane
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 4'b1110, 1, 32'd0, 1, 4'b1000, 32'hA500_0000, 32'd0, 1'b0, 1'b1);
    // LB / LBU / LH / LHU from lane 2
    issue(1'b1, 3'b000, 32'h0000_0202, 32'h1234_5678, 4'b1111, 1, 32'h0080_0000, 1, 4'b0100, 32'd0, 32'hFFFF_FF80, 1'b0, 1'b1);
    issue(1'b1, 3'b100, 32'h0000_0202, 32'h1234_5678, 4'b1111, 1, 32'h0080_0000, 1, 4'b0100, 32'd0, 32'h0000_0080, 1'b0, 1'b1);
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h0, 4'b1111, 1, 32'h8001_0000, 1, 4'b1100, 32'd0, 32'hFFFF_8001, 1'b0, 1'b1);
    issue(1'b1, 3'b101, 32'h0000_0302, 32'h0, 4'b1111, 1, 32'hFFFE_0000, 1, 4'b1100, 32'd0, 32'h0000_FFFE, 1'b0, 1'b1);
    // LW with ack in third cycle
    issue(1'b1, 3'b010, 32'h0000_0400, 32'h0, 4'b1111, 3, 32'hCAFE_F00D, 3, 4'b1111, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b1);
    // Misaligned LW and SH, no-op, load with strobes, illegal load funct3
    issue(1'b1, 3'b010, 32'h0000_0102, 32'h0, 4'b1111, 1, 32'hFFFF_FFFF, 0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    issue(1'b0, 3'b001, 32'h0000_0101, 32'hFFFF_FFFF, 4'b1100, 1, 32'd0, 0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    issue(1'b0, 3'b000, 32'h0000_0100, 32'hFFFF_FFFF, 4'b1111, 1, 32'd0, 0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    issue(1'b1, 3'b000, 32'h0000_0100, 32'h0, 4'b1110, 1, 32'hFFFF_FFFF, 0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    issue(1'b1, 3'b011, 32'h0000_0100, 32'h0, 4'b1111, 1, 32'hFFFF_FFFF, 0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    // Timeout, then ack exactly on the expiry cycle
    issue(1'b1, 3'b010, 32'h0000_0500, 32'h0, 4'b1111, 0, 32'hFFFF_FFFF, TIMEOUT, 4'b1111, 32'd0, 32'd0, 1'b1, 1'b1);
    issue(1'b1, 3'b010, 32'h0000_0504, 32'h0, 4'b1111, TIMEOUT, 32'h1122_3344, TIMEOUT, 4'b1111, 32'd0, 32'h1122_3344, 1'b0, 1'b1);

    // Reset while in BUS: op abandoned, no response
    issue(1'b1, 3'b010, 32'h0000_0600, 32'h0, 4'b1111, 0, 32'hFFFF_FFFF, 3, 4'b1111, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({req_ready, bus_cs, resp_valid} == 3'b000, "reset_mid_op", {69'd0, req_ready, bus_cs, resp_valid}, 72'd0);
    rst = 1'b0;
    // Stray ack while idle must be ignored
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    // Normal op after reset: SB into lane 1
    issue(1'b0, 3'b000, 32'h0000_0001, 32'h0000_005A, 4'b1110, 1, 32'd0, 1, 4'b0010, 32'h0000_5A00, 32'd0, 1'b0, 1'b1);

    w = 0;
    while ((resp_q.size() != 0 || bus_q.size() != 0) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    chk((resp_q.size() == 0) && (bus_q.size() == 0), "drain",
        {8'd0, 32'(resp_q.size()), 32'(bus_q.size())}, 72'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
